// File: rtl/machine_timer.sv
// machine_timer
// RISC-V machine timer: a 64-bit mtime counter advanced by Step on every
// cycle in which the timekeeper's tick is high, a 64-bit mtimecmp compare
// register, and the registered level interrupt mtip = (mtime >= mtimecmp).
// Both registers are reachable through a 32-bit word-addressed port.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   res    - asynchronous active-low reset
//   tick   - timebase pulse; mtime advances in every cycle it is high
//   sel    - register access request, one cycle
//   we     - 1 = write, 0 = read, qualified by sel
//   addr   - word index: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi
//   wdata  - write data
//   rdata  - read data, valid while ready=1, zero otherwise
//   ready  - one-cycle acknowledge, one cycle after every sel
//   mtip   - machine timer interrupt pending (level)
module machine_timer #(
  parameter logic [31:0] Step     = 32'd1,
  parameter logic [63:0] CmpReset = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        res,
  input  logic        tick,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        mtip
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        mtip_q, mtip_d;

  logic wr_en;
  logic rd_en;

  assign wr_en = sel & we;
  assign rd_en = sel & ~we;

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    hi_snap_d  = hi_snap_q;
    rdata_d    = 32'd0;
    ready_d    = sel;
    // Compare uses the registered values, so mtip lags register state by one cycle.
    mtip_d     = (mtime_q >= mtimecmp_q);

    if (tick) begin
      mtime_d = mtime_q + {32'd0, Step};
    end

    // A software write to either mtime half overrides the increment entirely;
    // the untouched half keeps its pre-edge value rather than any carry.
    if (wr_en) begin
      unique case (addr)
        2'd0: mtime_d = {mtime_q[63:32], wdata};
        2'd1: mtime_d = {wdata, mtime_q[31:0]};
        2'd2: mtimecmp_d = {mtimecmp_q[63:32], wdata};
        2'd3: mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        default: ;
      endcase
    end

    // Reading mtime_lo snapshots the high half so a following hi read is
    // coherent with it even if a tick carried in between.
    if (rd_en) begin
      unique case (addr)
        2'd0: begin
          rdata_d   = mtime_q[31:0];
          hi_snap_d = mtime_q[63:32];
        end
        2'd1: rdata_d = hi_snap_q;
        2'd2: rdata_d = mtimecmp_q[31:0];
        2'd3: rdata_d = mtimecmp_q[63:32];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= CmpReset;
      hi_snap_q  <= 32'd0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      hi_snap_q  <= hi_snap_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      mtip_q     <= mtip_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign mtip  = mtip_q;

endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer
// Bench for machine_timer: directed scenarios followed by randomized traffic,
// all compared against a reference model holding mtime/mtimecmp as plain
// 64-bit numbers and the software-visible snapshot of the high word.
module tb_machine_timer;

  localparam logic [31:0] Step = 32'd1;

  logic        clk;
  logic        res;
  logic        tick;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        mtip;

  int checks;
  int failures;

  // Reference model state
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic [31:0] m_snap;

  machine_timer #(
    .Step     (Step),
    .CmpReset (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk   (clk),
    .res   (res),
    .tick  (tick),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .mtip  (mtip)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_time = 64'd0;
    m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
    m_snap = 32'd0;
  endtask

  // Drives one cycle of inputs, advances the model with the rules of the
  // timer, then checks the outputs produced by that edge.
  task automatic applyStimulus(input logic t, input logic s, input logic w,
                               input logic [1:0] a, input logic [31:0] d);
    logic [31:0] exp_rdata;
    logic        exp_ready;
    logic        exp_mtip;
    tick  = t;
    sel   = s;
    we    = w;
    addr  = a;
    wdata = d;

    exp_ready = s;
    exp_rdata = 32'd0;
    exp_mtip  = (m_time >= m_cmp);
    if (s && !w) begin
      case (a)
        2'd0: begin
          exp_rdata = m_time[31:0];
          m_snap    = m_time[63:32];
        end
        2'd1: exp_rdata = m_snap;
        2'd2: exp_rdata = m_cmp[31:0];
        default: exp_rdata = m_cmp[63:32];
      endcase
    end

    if (s && w && a == 2'd0)      m_time[31:0]  = d;
    else if (s && w && a == 2'd1) m_time[63:32] = d;
    else if (t)                   m_time        = m_time + 64'(Step);
    if (s && w && a == 2'd2) m_cmp[31:0]  = d;
    if (s && w && a == 2'd3) m_cmp[63:32] = d;

    @(posedge clk);
    #1;
    checkOutput("ready", {63'd0, ready}, {63'd0, exp_ready});
    checkOutput("rdata", {32'd0, rdata}, {32'd0, exp_rdata});
    checkOutput("mtip",  {63'd0, mtip},  {63'd0, exp_mtip});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    applyStimulus(1'b0, 1'b1, 1'b0, a, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    modelReset();

    // Reset held with tick and sel active: everything stays quiet
    res   = 1'b0;
    tick  = 1'b1;
    sel   = 1'b1;
    we    = 1'b0;
    addr  = 2'd2;
    wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {63'd0, ready}, 64'd0);
    checkOutput("rst_rdata", {32'd0, rdata}, 64'd0);
    checkOutput("rst_mtip",  {63'd0, mtip},  64'd0);
    sel = 1'b0;
    res = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    rd(2'd2);
    checkOutput("cmp_lo_rst", {32'd0, rdata}, 64'hFFFF_FFFF);
    rd(2'd3);
    checkOutput("cmp_hi_rst", {32'd0, rdata}, 64'hFFFF_FFFF);

    // Ten spaced tick pulses
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
      idle(4);
    end
    rd(2'd0);
    checkOutput("ten_lo", {32'd0, rdata}, 64'd10);
    rd(2'd1);
    checkOutput("ten_hi", {32'd0, rdata}, 64'd0);

    // Carry from low to high word, then full 64-bit wrap
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    rd(2'd0);
    checkOutput("carry_lo", {32'd0, rdata}, 64'd0);
    rd(2'd1);
    checkOutput("carry_hi", {32'd0, rdata}, 64'd1);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    rd(2'd0);
    checkOutput("wrap_lo", {32'd0, rdata}, 64'd0);
    rd(2'd1);
    checkOutput("wrap_hi", {32'd0, rdata}, 64'd0);

    // Write in a tick cycle wins over the increment
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'd5);
    rd(2'd0);
    checkOutput("wr_wins", {32'd0, rdata}, 64'd5);

    // Interrupt rises after mtime reaches mtimecmp, drops after cmp raised
    wr(2'd2, 32'd3);
    wr(2'd3, 32'd0);
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    checkOutput("mtip_lag", {63'd0, mtip}, 64'd0);
    idle(1);
    checkOutput("mtip_rise", {63'd0, mtip}, 64'd1);
    wr(2'd2, 32'd100);
    checkOutput("mtip_hold", {63'd0, mtip}, 64'd1);
    idle(1);
    checkOutput("mtip_fall", {63'd0, mtip}, 64'd0);

    // Coherent lo/hi read across a carry
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'd0);
    rd(2'd0);
    checkOutput("coh_lo", {32'd0, rdata}, 64'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    rd(2'd1);
    checkOutput("coh_snap", {32'd0, rdata}, 64'd0);
    rd(2'd0);
    checkOutput("coh_lo2", {32'd0, rdata}, 64'd0);
    rd(2'd1);
    checkOutput("coh_hi2", {32'd0, rdata}, 64'd1);

    // Reset in the middle of a pending acknowledge
    rd(2'd2);
    #2;
    res = 1'b0;
    #1;
    checkOutput("abort_ready", {63'd0, ready}, 64'd0);
    checkOutput("abort_rdata", {32'd0, rdata}, 64'd0);
    modelReset();
    sel  = 1'b0;
    tick = 1'b0;
    @(posedge clk);
    #1;
    res = 1'b1;
    idle(2);
    rd(2'd1);
    checkOutput("snap_rst", {32'd0, rdata}, 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF :
          ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) == 0),
                    2'($urandom_range(0, 3)),
                    d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
